rainbow_light_ctrl: RTL

Parametrised multi-mode LED pattern generator, the successor to the fixed 8-bit rainbow light controller. It drives a WIDTH-bit LED bus with one of five selectable patterns: rotate left, rotate right, ping-pong, bar fill and blink. Pattern steps are paced by a programmable prescaler. The `control` input runs or pauses the pattern, and `step` gives downstream logic a one-cycle pulse on every pattern change.

---
 rtl/rainbow_light_ctrl_if.sv | 14 +
 rtl/rainbow_light_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/rainbow_light_ctrl_if.sv
// LED pattern generator bus: run/mode/speed controls in, LED pattern and step pulse out.
interface rainbow_light_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
);
  logic             control;
  logic [2:0]       mode;
  logic [DIV_W-1:0] speed;
  logic [WIDTH-1:0] dout;
  logic             step;

  modport master (output control, mode, speed, input dout, step);
  modport slave  (input control, mode, speed, output dout, step);
endinterface

// File: rtl/rainbow_light_ctrl.sv
// Multi-mode LED pattern generator: rotate L/R, ping-pong, bar fill, blink,
// paced by a prescaler that ticks every speed+1 run cycles.
module rainbow_light_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input logic             clk,
  input logic             rst,
  rainbow_light_ctrl_if.slave bus
);
  typedef enum logic {DIR_L, DIR_R} dir_e;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB  = ONE << (WIDTH-1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  dir_e             dir_q,  dir_d;
  logic [2:0]       mode_q, mode_d;
  logic             step_q, step_d;
  logic             tick;
  logic [WIDTH-1:0] seed;

  always_comb begin
    case (bus.mode)
      3'd1:    seed = MSB;
      3'd4:    seed = ONES;
      default: seed = ONE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    step_d = 1'b0;
    tick   = 1'b0;

    // Equality match only: a speed lowered below cnt lets cnt wrap before matching.
    if (bus.control) begin
      if (cnt_q == bus.speed) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (tick) begin
      step_d = 1'b1;
      if (bus.mode != mode_q) begin
        dout_d = seed;
        dir_d  = DIR_L;
        mode_d = bus.mode;
      end else begin
        case (mode_q)
          3'd1: dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
          3'd2: begin
            if (dir_q == DIR_L) begin
              dout_d = dout_q << 1;
              if (dout_d[WIDTH-1]) dir_d = DIR_R;
            end else begin
              dout_d = dout_q >> 1;
              if (dout_d[0]) dir_d = DIR_L;
            end
          end
          3'd3:    dout_d = (&dout_q) ? '0 : {dout_q[WIDTH-2:0], 1'b1};
          3'd4:    dout_d = (&dout_q) ? '0 : ONES;
          default: dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      dout_q <= ONE;
      dir_q  <= DIR_L;
      mode_q <= 3'd0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.step = step_q;
endmodule
